instr_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of the instruction decoder.

---
 rtl/yarp_pkg.sv | 13 +
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared types and constants for the yarp core pipeline.
package yarp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one imem request at a time, hands words to decode.
// Latency: request -> instr_valid_o two cycles later with immediate grant and one-cycle response.
// Backpressure: holds the fetched word until decode accepts; redirect discards stale work.
module instr_fetch
    import yarp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  redirect_tgt;

    assign redirect_tgt  = {redirect_pc_i[31:2], 2'b00};
    assign imem_req_o    = (state_q == S_REQ);
    assign imem_addr_o   = pc_q;
    // Redirect suppresses valid in the same cycle so a stale word never reaches decode.
    assign instr_valid_o = (state_q == S_HOLD) & ~redirect_i;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        drop_d   = drop_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;

        if (redirect_i) begin
            pc_d = redirect_tgt;
            unique case (state_q)
                S_IDLE: ;
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD: state_d = S_REQ;
                default: state_d = S_IDLE;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            instr_d  = imem_rdata_i;
                            pc_out_d = pc_q;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready_i) begin
                        pc_d    = pc_q + INSTR_BYTES;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            drop_q   <= 1'b0;
            instr_q  <= 32'h0;
            pc_out_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            drop_q   <= drop_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Random-phase model state.
    logic [31:0] exp_pc;
    logic        fetch_chk;
    logic [31:0] fetch_addr;
    logic        pending;
    logic [31:0] pend_addr;
    int          pend_delay;
    int          n_xfer;

    initial begin
        reset_n       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;

        // 1: reset state, first fetch and handoff
        repeat (3) @(posedge clk);
        #2;
        check("rst_req",   {31'b0, imem_req_o},    32'd0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc_o",  pc_o,    32'h0);
        reset_n = 1'b1;
        cyc(); imem_gnt_i = 1'b1; #1;
        check("t1_req",  {31'b0, imem_req_o}, 32'd1);
        check("t1_addr", imem_addr_o, 32'h0);
        cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093; #1;
        check("t1_wait_valid", {31'b0, instr_valid_o}, 32'd0);
        cyc(); imem_rvalid_i = 1'b0; instr_ready_i = 1'b1; #1;
        check("t1_valid", {31'b0, instr_valid_o}, 32'd1);
        check("t1_instr", instr_o, 32'h0050_0093);
        check("t1_pc",    pc_o,    32'h0);
        cyc(); instr_ready_i = 1'b0; imem_gnt_i = 1'b1; #1;
        check("t1_next_req",  {31'b0, imem_req_o}, 32'd1);
        check("t1_next_addr", imem_addr_o, 32'h4);

        // 2: decode stall holds the word
        cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h00A0_0113; #1;
        cyc(); imem_rvalid_i = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", {31'b0, instr_valid_o}, 32'd1);
            check("t2_hold_instr", instr_o, 32'h00A0_0113);
            check("t2_hold_pc",    pc_o,    32'h4);
            check("t2_hold_noreq", {31'b0, imem_req_o}, 32'd0);
            cyc(); #1;
        end
        instr_ready_i = 1'b1;
        cyc(); instr_ready_i = 1'b0; #1;
        check("t2_next_addr", imem_addr_o, 32'h8);

        // 5: grant withheld keeps request and address stable
        for (int i = 0; i < 4; i++) begin
            check("t5_req",  {31'b0, imem_req_o}, 32'd1);
            check("t5_addr", imem_addr_o, 32'h8);
            cyc(); #1;
        end
        imem_gnt_i = 1'b1;
        cyc(); imem_gnt_i = 1'b0; #1;
        check("t5_waiting", {31'b0, imem_req_o}, 32'd0);

        // 3: redirect in S_WAIT drops the late response
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        cyc(); redirect_i = 1'b0; #1;
        check("t3_no_req_drop", {31'b0, imem_req_o}, 32'd0);
        cyc(); imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; #1;
        check("t3_drop_valid", {31'b0, instr_valid_o}, 32'd0);
        cyc(); imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; #1;
        check("t3_valid_after", {31'b0, instr_valid_o}, 32'd0);
        check("t3_req",  {31'b0, imem_req_o}, 32'd1);
        check("t3_addr", imem_addr_o, 32'h100);

        // 4: redirect in S_HOLD with ready blocks the transfer
        cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111; #1;
        cyc(); imem_rvalid_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200; instr_ready_i = 1'b1; #1;
        check("t4_valid_masked", {31'b0, instr_valid_o}, 32'd0);
        cyc(); redirect_i = 1'b0; instr_ready_i = 1'b0; imem_gnt_i = 1'b1; #1;
        check("t4_req",  {31'b0, imem_req_o}, 32'd1);
        check("t4_addr", imem_addr_o, 32'h200);

        // 6: redirect with same-cycle response, then PC wrap
        cyc(); imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333; #1;
        check("t6_valid_masked", {31'b0, instr_valid_o}, 32'd0);
        cyc(); redirect_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; #1;
        check("t6_req",  {31'b0, imem_req_o}, 32'd1);
        check("t6_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222; #1;
        cyc(); imem_rvalid_i = 1'b0; instr_ready_i = 1'b1; #1;
        check("t6_valid", {31'b0, instr_valid_o}, 32'd1);
        check("t6_instr", instr_o, 32'h2222_2222);
        check("t6_pc",    pc_o,    32'hFFFF_FFFC);
        cyc(); instr_ready_i = 1'b0; #1;
        check("t6_wrap_req",  {31'b0, imem_req_o}, 32'd1);
        check("t6_wrap_addr", imem_addr_o, 32'h0);

        // Randomized run against the fetch-stream model
        cyc(); reset_n = 1'b0;
        cyc(); reset_n = 1'b1;
        exp_pc     = 32'h0;
        fetch_chk  = 1'b1;
        fetch_addr = 32'h0;
        pending    = 1'b0;
        pend_addr  = 32'h0;
        pend_delay = 0;
        n_xfer     = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            imem_gnt_i    = ($urandom % 3) != 0;
            instr_ready_i = ($urandom % 4) != 0;
            if (redirect_i && ($urandom % 2 == 0)) begin
                redirect_pc_i = $urandom;
            end else begin
                redirect_i    = ($urandom % 14) == 0;
                redirect_pc_i = $urandom;
            end
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (pending) begin
                if (pend_delay == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(pend_addr);
                    pending       = 1'b0;
                end else begin
                    pend_delay--;
                end
            end
            #1;
            if (redirect_i) begin
                check("rnd_valid_on_redirect", {31'b0, instr_valid_o}, 32'd0);
            end
            if (instr_valid_o && instr_ready_i) begin
                check("rnd_pc",    pc_o,    exp_pc);
                check("rnd_instr", instr_o, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (imem_req_o && imem_gnt_i) begin
                check("rnd_one_outstanding", {31'b0, pending}, 32'd0);
                check("rnd_addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
                if (fetch_chk && !redirect_i) begin
                    check("rnd_redirect_addr", imem_addr_o, fetch_addr);
                    fetch_chk = 1'b0;
                end
                pending    = 1'b1;
                pend_addr  = imem_addr_o;
                pend_delay = $urandom % 4;
            end
            if (redirect_i) begin
                exp_pc     = {redirect_pc_i[31:2], 2'b00};
                fetch_chk  = 1'b1;
                fetch_addr = exp_pc;
            end
        end
        redirect_i = 1'b0;
        check("rnd_progress", {31'b0, (n_xfer > 100)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
